mac_accum32: RTL and testbench
==============================

Name: mac_accum32

Overview:
- Signed multiply-accumulate stage that sits directly downstream of the 32-bit constant generator.
- Multiplies each incoming 32-bit signed sample by the 32-bit signed coefficient that the constant generator drives.
- Accumulates N products into a wide accumulator, then emits one scaled, saturated 32-bit result per block of N samples.
- Uses a valid/ready handshake on both input and output, so it drops into the datapath between a sample source and the next processing stage.

Parameters:
- N_SAMPLES, 8, products summed per output block; legal range 1..256.
- SHIFT, 0, arithmetic right shift applied to the final sum before saturation; legal range 0..63.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- coeff  input  32  signed coefficient; driven by the constant generator; sampled on every input handshake.
- clear  input  1  synchronous abort; discards the current block.
- in_data  input  32  signed sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a sample this cycle.
- out_data  output  32  signed, scaled, saturated block result.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (reset_n low, asynchronous, effective immediately):
  - state=ACC, count=0, acc=0, prod=0, prod_v=0.
  - in_ready=0 while reset_n is low; in_ready=1 from the first clk after release.
  - out_valid=0, out_data=0.
  - A reset mid-block discards all partial state.
- Widths:
  - prod is 64-bit signed and equals in_data*coeff, computed at full precision.
  - acc is 73-bit signed (64+9), so 256 full-scale products cannot overflow.
- Handshake: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Pipeline:
  - On an input transfer: prod <= in_data*coeff, prod_v <= 1, count <= count+1.
  - With no input transfer: prod_v <= 0.
  - Any cycle with prod_v=1: acc <= acc + sign-extended prod.
- State ACC:
  - in_ready=1, out_valid=0.
  - The transfer that makes count reach N_SAMPLES moves the state to FLUSH.
- State FLUSH (exactly one cycle):
  - in_ready=0.
  - The last product is added in this cycle.
  - out_data <= sat32((acc + prod) >>> SHIFT).
  - Next state is OUT.
- State OUT:
  - out_valid=1, in_ready=0.
  - out_data is held stable until an output transfer.
  - On the output transfer: acc=0, count=0, next state ACC, out_valid=0 on the next cycle.
  - in_valid is ignored throughout OUT.
- Latency: the Nth input transfer happens at cycle t; out_valid rises at t+2. Minimum block period is N_SAMPLES+2 cycles when out_ready is held high.
- Scaling and saturation:
  - The shift is arithmetic, so it truncates toward negative infinity.
  - sat32 clamps the result to [-2147483648, 2147483647], i.e. 0x80000000..0x7FFFFFFF.
- clear:
  - From any state: state=ACC, acc=0, count=0, prod_v=0, out_valid=0 on the next cycle.
  - clear overrides a simultaneous input or output transfer; that transfer is dropped.
  - out_data keeps its last value.
- N_SAMPLES=1: every accepted sample produces one output, and the block period is 3 cycles.
- coeff changes between samples take effect per sample; each product uses the coeff value present at that sample's transfer.
- in_valid may be held high across OUT. No sample is consumed until the state returns to ACC.

Test Plan:
- Basic sum: N=4, SHIFT=0, coeff=3, in_data 1,2,3,4 on back-to-back cycles with out_ready=1 -> out_data=30. out_valid is high for exactly one cycle, 2 cycles after the 4th transfer. in_ready=0 during FLUSH and OUT.
- Signed mix: N=4, coeff=-2, in_data 5,-7,10,1 -> out_data=-18 (0xFFFFFFEE).
- Saturation:
  - N=4, coeff=0x7FFFFFFF, four samples of 0x7FFFFFFF -> out_data=0x7FFFFFFF.
  - coeff=0x80000000, four samples of 0x7FFFFFFF -> out_data=0x80000000.
- Backpressure: N=4, out_ready=0 for 5 cycles after out_valid rises, in_valid held high with in_data=9 -> out_data stable, in_ready=0, no samples consumed. After out_ready=1, the next block with coeff=1 and four samples of 9 -> out_data=36 (accumulator restarted from 0).
- Shift and rounding: N=4, SHIFT=4, coeff=16, in_data 1,1,1,1 -> 4. Then N=1, SHIFT=4, coeff=1, in_data=-1 -> -1 (floor, not 0).
- Reset and clear mid-block:
  - N=4, accept 2 samples of 100 with coeff=1, then pull reset_n low asynchronously between clk edges -> out_valid=0 and out_data=0 immediately. After release, samples 1,1,1,1 -> out_data=4.
  - Repeat the same sequence using clear instead of reset_n -> the same 4 results.

Source files
------------

// File: rtl/mac_accum32.sv
// mac_accum32: signed multiply-accumulate over blocks of N_SAMPLES with scaled, saturated output
module mac_accum32 #(
  parameter int N_SAMPLES = 8,
  parameter int SHIFT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] coeff,
  input  logic        clear,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {ACC, FLUSH, OUT} state_t;
  state_t state;
  logic [8:0] count;
  logic signed [63:0] prod, product;
  logic signed [72:0] acc, sum, scaled;
  logic prod_v, in_xfer, out_xfer, last;
  logic [31:0] sat;
  // full-precision product, running sum with the pending product folded in, then scale and clamp
  always_comb begin
    in_xfer = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    last = count + 9'd1 == 9'(N_SAMPLES);
    product = {{32{in_data[31]}}, in_data} * {{32{coeff[31]}}, coeff};
    sum = acc + (prod_v ? {{9{prod[63]}}, prod} : 73'd0);
    scaled = sum >>> SHIFT;
    sat = (&scaled[72:31] || ~|scaled[72:31]) ? scaled[31:0] : scaled[72] ? 32'h8000_0000 : 32'h7fff_ffff;
  end
  // block FSM with registered handshake outputs, product pipeline and accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACC;
      count <= '0;
      acc <= '0;
      prod <= '0;
      prod_v <= 1'b0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (clear) begin
      state <= ACC;
      count <= '0;
      acc <= '0;
      prod_v <= 1'b0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      acc <= sum;
      prod_v <= in_xfer;
      if (in_xfer) begin
        prod <= product;
        count <= count + 9'd1;
      end
      case (state)
        ACC: begin
          state <= in_xfer && last ? FLUSH : ACC;
          in_ready <= !(in_xfer && last);
        end
        FLUSH: begin
          out_data <= sat;
          out_valid <= 1'b1;
          state <= OUT;
        end
        default: if (out_xfer) begin
          state <= ACC;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          acc <= '0;
          count <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_accum32.sv
// tb_mac_accum32: randomized and directed checks of mac_accum32 against an arithmetic reference
module tb_mac_accum32;
  typedef logic signed [31:0] q_t[$];
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] coeff = '0, in_data = '0;
  logic [2:0] rdy, vld;
  logic [31:0] dat [3];
  int checks = 0, errors = 0;
  int n_of[3] = '{4, 4, 1};
  int sh_of[3] = '{0, 4, 4};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mac_accum32 #(.N_SAMPLES(g == 2 ? 1 : 4), .SHIFT(g == 0 ? 0 : 4)) dut (
      .clk(clk), .reset_n(reset_n), .coeff(coeff), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[g]),
      .out_data(dat[g]), .out_valid(vld[g]), .out_ready(out_ready)
    );
  end

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  function automatic logic [31:0] model(input q_t d, input q_t c, input int sh);
    logic signed [127:0] s;
    s = '0;
    foreach (d[i]) s += 128'(d[i]) * 128'(c[i]);
    s = s >>> sh;
    if (s > 128'sd2147483647) return 32'h7fff_ffff;
    if (s < -128'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic logic signed [31:0] rnd();
    case ($urandom_range(0, 4))
      0: return 32'sh7fff_ffff;
      1: return 32'sh8000_0000;
      2: return 32'($urandom_range(0, 40)) - 32'sd20;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    in_valid = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_samples(input int u, input q_t d, input q_t c, input bit gaps);
    foreach (d[i]) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data = d[i];
      coeff = c[i];
      for (int g = 0; g < 20 && !rdy[u]; g++) tick();
      if (!rdy[u]) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout dut=%0d got=0 want=1", u);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_block(input int u, input q_t d, input q_t c, input bit gaps,
                           output logic fr, output int lat, output logic [31:0] res);
    send_samples(u, d, c, gaps);
    fr = rdy[u];
    lat = 0;
    while (!vld[u] && lat < 10) begin
      tick();
      lat++;
    end
    res = dat[u];
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (rdy !== 3'b000 || vld !== 3'b000) begin
      errors++;
      $display("FAIL reset_handshake got=rdy%b/vld%b want=000/000", rdy, vld);
    end
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (dat[u] !== 32'd0) begin
        errors++;
        $display("FAIL reset_out_data dut=%0d got=%h want=0", u, dat[u]);
      end
    end
    reset_n = 1'b1;
    checks++;
    if (rdy !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_ready got=%b want=000", rdy);
    end
    tick();
    checks++;
    if (rdy !== 3'b111) begin
      errors++;
      $display("FAIL reset_first_clk_ready got=%b want=111", rdy);
    end
  endtask

  task automatic test_basic();
    q_t d, c;
    logic fr;
    int lat;
    logic [31:0] res;
    pulse_clear();
    d = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
    c = '{32'sd3, 32'sd3, 32'sd3, 32'sd3};
    run_block(0, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'd30) begin
      errors++;
      $display("FAIL basic_sum got=%0d want=30", $signed(res));
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL basic_latency got=%0d want=1", lat);
    end
    checks++;
    if (fr !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_flush_out got=%b%b want=00", fr, rdy[0]);
    end
    tick();
    checks++;
    if (vld[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_one_cycle got=vld%b/rdy%b want=0/1", vld[0], rdy[0]);
    end
  endtask

  task automatic test_signed();
    q_t d, c;
    logic fr;
    int lat;
    logic [31:0] res;
    pulse_clear();
    d = '{32'sd5, -32'sd7, 32'sd10, 32'sd1};
    c = '{-32'sd2, -32'sd2, -32'sd2, -32'sd2};
    run_block(0, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'hffff_ffee) begin
      errors++;
      $display("FAIL signed_mix got=%h want=ffffffee", res);
    end
    tick();
  endtask

  task automatic test_saturation();
    q_t d, c;
    logic fr;
    int lat;
    logic [31:0] res;
    pulse_clear();
    d = '{32'sh7fff_ffff, 32'sh7fff_ffff, 32'sh7fff_ffff, 32'sh7fff_ffff};
    c = d;
    run_block(0, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'h7fff_ffff) begin
      errors++;
      $display("FAIL sat_positive got=%h want=7fffffff", res);
    end
    tick();
    c = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000};
    run_block(0, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sat_negative got=%h want=80000000", res);
    end
    tick();
  endtask

  task automatic test_backpressure();
    q_t d, c;
    logic fr;
    int lat;
    logic [31:0] res;
    pulse_clear();
    out_ready = 1'b0;
    d = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
    c = '{32'sd3, 32'sd3, 32'sd3, 32'sd3};
    run_block(0, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'd30 || lat !== 1) begin
      errors++;
      $display("FAIL bp_first_block got=%0d/lat%0d want=30/lat1", $signed(res), lat);
    end
    in_valid = 1'b1;
    in_data = 32'd9;
    coeff = 32'd1;
    for (int h = 0; h < 5; h++) begin
      tick();
      checks++;
      if (vld[0] !== 1'b1 || rdy[0] !== 1'b0 || dat[0] !== 32'd30) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got=vld%b/rdy%b/%0d want=1/0/30", h, vld[0], rdy[0], dat[0]);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (vld[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got=vld%b/rdy%b want=0/1", vld[0], rdy[0]);
    end
    d = '{32'sd9, 32'sd9, 32'sd9, 32'sd9};
    c = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
    run_block(0, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'd36) begin
      errors++;
      $display("FAIL bp_second_block got=%0d want=36", $signed(res));
    end
    tick();
  endtask

  task automatic test_shift();
    q_t d, c;
    logic fr;
    int lat;
    logic [31:0] res;
    pulse_clear();
    d = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
    c = '{32'sd16, 32'sd16, 32'sd16, 32'sd16};
    run_block(1, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'd4) begin
      errors++;
      $display("FAIL shift_scale got=%0d want=4", $signed(res));
    end
    tick();
    pulse_clear();
    d = '{-32'sd1};
    c = '{32'sd1};
    run_block(2, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'hffff_ffff || lat !== 1) begin
      errors++;
      $display("FAIL shift_floor got=%0d/lat%0d want=-1/lat1", $signed(res), lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int xfers, outs;
    logic [31:0] last;
    pulse_clear();
    xfers = 0;
    outs = 0;
    last = '0;
    in_valid = 1'b1;
    in_data = 32'd100;
    coeff = 32'd5;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (rdy[2]) xfers++;
      if (vld[2]) begin
        outs++;
        last = dat[2];
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (xfers !== 3 || outs !== 3) begin
      errors++;
      $display("FAIL b2b_period got=%0d/%0d want=3/3", xfers, outs);
    end
    checks++;
    if (last !== 32'd31) begin
      errors++;
      $display("FAIL b2b_value got=%0d want=31", $signed(last));
    end
  endtask

  task automatic test_reset_mid();
    q_t d, c;
    logic fr;
    int lat;
    logic [31:0] res;
    pulse_clear();
    d = '{32'sd100, 32'sd100};
    c = '{32'sd1, 32'sd1};
    send_samples(0, d, c, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (vld[0] !== 1'b0 || dat[0] !== 32'd0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got=vld%b/rdy%b/%h want=0/0/0", vld[0], rdy[0], dat[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    d = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
    c = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
    run_block(0, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'd4 || lat !== 1) begin
      errors++;
      $display("FAIL reset_mid_result got=%0d/lat%0d want=4/lat1", $signed(res), lat);
    end
    tick();
  endtask

  task automatic test_clear_mid();
    q_t d, c;
    logic fr;
    int lat;
    logic [31:0] res;
    pulse_clear();
    d = '{32'sd100, 32'sd100};
    c = '{32'sd1, 32'sd1};
    send_samples(0, d, c, 1'b0);
    pulse_clear();
    checks++;
    if (vld[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL clear_mid_state got=vld%b/rdy%b want=0/1", vld[0], rdy[0]);
    end
    d = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
    c = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
    run_block(0, d, c, 1'b0, fr, lat, res);
    checks++;
    if (res !== 32'd4) begin
      errors++;
      $display("FAIL clear_mid_result got=%0d want=4", $signed(res));
    end
    tick();
    out_ready = 1'b0;
    d = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
    c = '{32'sd3, 32'sd3, 32'sd3, 32'sd3};
    run_block(0, d, c, 1'b0, fr, lat, res);
    clear = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (vld[0] !== 1'b0 || rdy[0] !== 1'b1 || dat[0] !== 32'd30) begin
      errors++;
      $display("FAIL clear_in_out got=vld%b/rdy%b/%0d want=0/1/30", vld[0], rdy[0], dat[0]);
    end
  endtask

  task automatic test_random();
    q_t d, c;
    logic fr;
    int lat, hold;
    logic [31:0] res, exp_v;
    for (int u = 0; u < 3; u++) begin
      for (int b = 0; b < 12; b++) begin
        pulse_clear();
        d = {};
        c = {};
        for (int k = 0; k < n_of[u]; k++) begin
          d.push_back(rnd());
          c.push_back(rnd());
        end
        exp_v = model(d, c, sh_of[u]);
        hold = $urandom_range(0, 2);
        out_ready = hold == 0;
        run_block(u, d, c, 1'b1, fr, lat, res);
        checks++;
        if (res !== exp_v || lat !== 1) begin
          errors++;
          $display("FAIL rand_result dut=%0d blk=%0d got=%h/lat%0d want=%h/lat1", u, b, res, lat, exp_v);
        end
        for (int h = 0; h < hold; h++) begin
          tick();
          checks++;
          if (vld[u] !== 1'b1 || dat[u] !== exp_v) begin
            errors++;
            $display("FAIL rand_hold dut=%0d got=vld%b/%h want=1/%h", u, vld[u], dat[u], exp_v);
          end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (vld[u] !== 1'b0) begin
          errors++;
          $display("FAIL rand_release dut=%0d got=%b want=0", u, vld[u]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_saturation();
    test_backpressure();
    test_shift();
    test_back_to_back();
    test_reset_mid();
    test_clear_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
